// File: rtl/romulusn_ctrl_if.sv
// Host-side handshake bundle for romulusn_ctrl: command channel plus the sdi (key),
// pdi (nonce/data) and pdo (output) word channels.
interface romulusn_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_domain;
  logic       cmd_dec;
  logic       sdi_valid;
  logic       sdi_ready;
  logic       pdi_valid;
  logic       pdi_ready;
  logic       pdo_valid;
  logic       pdo_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_domain, cmd_dec, sdi_valid, pdi_valid, pdo_ready,
    input  cmd_ready, sdi_ready, pdi_ready, pdo_valid
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_domain, cmd_dec, sdi_valid, pdi_valid, pdo_ready,
    output cmd_ready, sdi_ready, pdi_ready, pdo_valid
  );
endinterface

// File: rtl/romulusn_ctrl.sv
// Romulus-N block sequencer: command FSM, word handshakes, datapath strobes and round constants.
// Optional feature macro: ROMULUSN_DECRYPT_EN (honour cmd_dec and drive the decrypt lane mask).
module romulusn_ctrl #(
  parameter int ROUNDS_PER_CYC = 2,
  parameter int NCYC           = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  romulusn_ctrl_if.slave        bus,
  output logic                  srst,
  output logic                  senc,
  output logic                  sse,
  output logic                  xrst,
  output logic                  xenc,
  output logic                  xse,
  output logic                  yrst,
  output logic                  yenc,
  output logic                  yse,
  output logic                  zrst,
  output logic                  zenc,
  output logic                  zse,
  output logic                  erst,
  output logic                  correct_cnt,
  output logic [5:0]            constant,
  output logic [5:0]            constant2,
  output logic                  tk1s,
  output logic [7:0]            domain,
  output logic [3:0]            decrypt,
  output logic                  busy
);

  typedef enum logic [2:0] {S_POR, S_IDLE, S_KEY, S_NONCE, S_DATA, S_ENC, S_TAG} state_e;
  typedef enum logic [2:0] {
    OP_LDKEY = 3'd0, OP_LDNONCE = 3'd1, OP_AD = 3'd2, OP_MSG = 3'd3, OP_TAG = 3'd4
  } op_e;

  localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [1:0]      beat_q, beat_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [5:0]      rc_q, rc_d, rc_n;
  logic            first_blk_q, first_blk_d;
  logic [7:0]      domain_q, domain_d;
  logic            dec_q, dec_d;
  logic            beat;

  function automatic logic [5:0] rc_step(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_POR;
      op_q        <= OP_LDKEY;
      beat_q      <= '0;
      cyc_q       <= '0;
      rc_q        <= '0;
      first_blk_q <= 1'b0;
      domain_q    <= '0;
      dec_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      beat_q      <= beat_d;
      cyc_q       <= cyc_d;
      rc_q        <= rc_d;
      first_blk_q <= first_blk_d;
      domain_q    <= domain_d;
      dec_q       <= dec_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    beat_d        = beat_q;
    cyc_d         = cyc_q;
    rc_d          = rc_q;
    first_blk_d   = first_blk_q;
    domain_d      = domain_q;
    dec_d         = dec_q;
    beat          = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.sdi_ready = 1'b0;
    bus.pdi_ready = 1'b0;
    bus.pdo_valid = 1'b0;
    srst = 1'b0; senc = 1'b0; sse = 1'b0;
    xrst = 1'b0; xenc = 1'b0; xse = 1'b0;
    yrst = 1'b0; yenc = 1'b0; yse = 1'b0;
    zrst = 1'b0; zenc = 1'b0; zse = 1'b0;
    erst      = 1'b0;
    constant  = '0;
    constant2 = '0;
    decrypt   = '0;

    rc_n = rc_q;
    for (int r = 0; r < ROUNDS_PER_CYC; r++) rc_n = rc_step(rc_n);

    unique case (state_q)
      S_POR: begin
        srst    = 1'b1;
        xrst    = 1'b1;
        yrst    = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        // Unknown opcodes are consumed and dropped without touching the latched context.
        if (bus.cmd_valid && bus.cmd_op <= 3'd4) begin
          op_d     = op_e'(bus.cmd_op);
          domain_d = bus.cmd_domain;
          beat_d   = '0;
`ifdef ROMULUSN_DECRYPT_EN
          dec_d    = bus.cmd_dec;
`endif
          unique case (op_e'(bus.cmd_op))
            OP_LDKEY:      state_d = S_KEY;
            OP_LDNONCE: begin
              state_d = S_NONCE;
              zrst    = 1'b1;
            end
            OP_AD, OP_MSG: state_d = S_DATA;
            OP_TAG:        state_d = S_TAG;
            default:       state_d = S_IDLE;
          endcase
        end
      end
      S_KEY: begin
        bus.sdi_ready = 1'b1;
        beat          = bus.sdi_valid;
        xse           = beat;
      end
      S_NONCE: begin
        bus.pdi_ready = 1'b1;
        beat          = bus.pdi_valid;
        yse           = beat;
      end
      S_DATA: begin
        // MSG words pass straight through, so a beat needs the output side ready as well.
        bus.pdi_ready = (op_q == OP_AD) || bus.pdo_ready;
        bus.pdo_valid = (op_q == OP_MSG) && bus.pdi_valid;
        beat          = bus.pdi_valid && bus.pdi_ready;
        sse           = beat;
`ifdef ROMULUSN_DECRYPT_EN
        decrypt       = (op_q == OP_MSG) ? {4{dec_q}} : 4'h0;
`endif
      end
      S_ENC: begin
        senc      = 1'b1;
        xenc      = 1'b1;
        yenc      = 1'b1;
        zenc      = 1'b1;
        constant  = rc_step(rc_q);
        constant2 = rc_step(rc_step(rc_q));
        rc_d      = rc_n;
        cyc_d     = cyc_q + 1'b1;
        if (cyc_q == CW'(NCYC - 1)) begin
          erst        = 1'b1;
          cyc_d       = '0;
          state_d     = S_IDLE;
          first_blk_d = 1'b0;
        end
      end
      S_TAG: begin
        bus.pdo_valid = 1'b1;
        beat          = bus.pdo_ready;
        sse           = beat;
      end
      default: state_d = S_IDLE;
    endcase

    if (beat) begin
      beat_d = beat_q + 2'd1;
      if (beat_q == 2'd3) begin
        unique case (state_q)
          S_NONCE: begin
            state_d     = S_IDLE;
            first_blk_d = 1'b1;
          end
          S_DATA: begin
            state_d = S_ENC;
            cyc_d   = '0;
            rc_d    = '0;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    correct_cnt = first_blk_q;
    tk1s        = (op_q == OP_AD);
    domain      = domain_q;
    busy        = (state_q != S_IDLE);

    // Outputs go quiet the instant reset is asserted, independent of the clock.
    if (!rst) begin
      bus.cmd_ready = 1'b0;
      bus.sdi_ready = 1'b0;
      bus.pdi_ready = 1'b0;
      bus.pdo_valid = 1'b0;
      srst = 1'b0; senc = 1'b0; sse = 1'b0;
      xrst = 1'b0; xenc = 1'b0; xse = 1'b0;
      yrst = 1'b0; yenc = 1'b0; yse = 1'b0;
      zrst = 1'b0; zenc = 1'b0; zse = 1'b0;
      erst        = 1'b0;
      constant    = '0;
      constant2   = '0;
      decrypt     = '0;
      correct_cnt = 1'b0;
      tk1s        = 1'b0;
      domain      = '0;
      busy        = 1'b0;
    end
  end

endmodule

// File: tb/tb_romulusn_ctrl.sv
// Self-checking bench for romulusn_ctrl: directed scenarios plus randomized command streams,
// compared every cycle against a behavioural model of the sequencer's rules.
module tb_romulusn_ctrl;

  localparam int NCYC = 20;
`ifdef ROMULUSN_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse, erst;
  logic correct_cnt, tk1s, busy;
  logic [5:0] constant, constant2;
  logic [7:0] domain;
  logic [3:0] decrypt;

  romulusn_ctrl_if bus ();

  romulusn_ctrl #(.ROUNDS_PER_CYC(2), .NCYC(NCYC)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .srst(srst), .senc(senc), .sse(sse),
    .xrst(xrst), .xenc(xenc), .xse(xse),
    .yrst(yrst), .yenc(yenc), .yse(yse),
    .zrst(zrst), .zenc(zenc), .zse(zse),
    .erst(erst), .correct_cnt(correct_cnt),
    .constant(constant), .constant2(constant2),
    .tk1s(tk1s), .domain(domain), .decrypt(decrypt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Round-constant sequence c(k): k LFSR steps from zero.
  int c_tbl [0:2*NCYC+2];

  // Behavioural model of the sequencer.
  string      m_mode  = "por";
  int         m_left  = 0;
  int         m_enc   = 0;
  int         m_op    = 0;
  bit         m_first = 1'b0;
  logic [7:0] m_dom   = 8'h00;
  bit         m_dec   = 1'b0;

  logic [12:0] e_strb;
  logic [4:0]  e_hs;
  logic [11:0] e_rc;
  logic [13:0] e_misc;

  // Pulse counters and ENC-run observations, written only by the compare process.
  int         xse_cnt = 0, yse_cnt = 0, sse_cnt = 0, zrst_cnt = 0;
  int         enc_run = 0, last_len = 0, erst_pos = 0;
  logic [5:0] first_c = '0, first_c2 = '0;

  initial begin : compare_proc
    bit e_srst, e_senc, e_sse, e_xrst, e_xenc, e_xse, e_yrst, e_yenc, e_yse, e_zrst, e_erst;
    bit e_cmd_rdy, e_sdi_rdy, e_pdi_rdy, e_pdo_vld, e_busy, e_corr, e_tk1s;
    logic [5:0] e_c1, e_c2;
    logic [3:0] e_dec;
    logic [7:0] e_dom;
    string nxt;
    forever begin
      @(negedge clk);
      #2;
      {e_srst, e_senc, e_sse, e_xrst, e_xenc, e_xse, e_yrst, e_yenc, e_yse, e_zrst, e_erst} = '0;
      {e_cmd_rdy, e_sdi_rdy, e_pdi_rdy, e_pdo_vld, e_busy, e_corr, e_tk1s} = '0;
      e_c1 = '0; e_c2 = '0; e_dec = '0; e_dom = '0;
      nxt = m_mode;
      if (!rst) begin
        nxt = "por"; m_first = 1'b0; m_op = 0; m_dom = 8'h00; m_dec = 1'b0;
      end else begin
        e_corr = m_first;
        e_tk1s = (m_op == 2);
        e_dom  = m_dom;
        e_busy = (m_mode != "idle");
        if (m_mode == "por") begin
          e_srst = 1; e_xrst = 1; e_yrst = 1;
          nxt = "idle";
        end else if (m_mode == "idle") begin
          e_cmd_rdy = 1;
          if (bus.cmd_valid && bus.cmd_op <= 3'd4) begin
            m_op = int'(bus.cmd_op); m_dom = bus.cmd_domain; m_dec = bus.cmd_dec; m_left = 4;
            case (m_op)
              0: nxt = "key";
              1: begin nxt = "nonce"; e_zrst = 1; end
              4: nxt = "tag";
              default: nxt = "data";
            endcase
          end
        end else if (m_mode == "key") begin
          e_sdi_rdy = 1;
          e_xse = bus.sdi_valid;
          if (e_xse) m_left--;
          if (m_left == 0) nxt = "idle";
        end else if (m_mode == "nonce") begin
          e_pdi_rdy = 1;
          e_yse = bus.pdi_valid;
          if (e_yse) m_left--;
          if (m_left == 0) begin nxt = "idle"; m_first = 1'b1; end
        end else if (m_mode == "data") begin
          e_pdi_rdy = (m_op == 2) || bus.pdo_ready;
          e_pdo_vld = (m_op == 3) && bus.pdi_valid;
          e_sse     = bus.pdi_valid && e_pdi_rdy;
          e_dec     = (m_op == 3 && m_dec && DEC_EN) ? 4'hF : 4'h0;
          if (e_sse) m_left--;
          if (m_left == 0) begin nxt = "enc"; m_enc = 0; end
        end else if (m_mode == "enc") begin
          e_senc = 1; e_xenc = 1; e_yenc = 1;
          e_c1   = 6'(c_tbl[2*m_enc + 1]);
          e_c2   = 6'(c_tbl[2*m_enc + 2]);
          e_erst = (m_enc == NCYC - 1);
          m_enc++;
          if (m_enc == NCYC) begin nxt = "idle"; m_first = 1'b0; end
        end else if (m_mode == "tag") begin
          e_pdo_vld = 1;
          e_sse = bus.pdo_ready;
          if (e_sse) m_left--;
          if (m_left == 0) nxt = "idle";
        end
      end
      e_strb = {e_srst, e_senc, e_sse, e_xrst, e_xenc, e_xse, e_yrst, e_yenc, e_yse,
                e_zrst, e_senc, 1'b0, e_erst};
      e_hs   = {e_cmd_rdy, e_sdi_rdy, e_pdi_rdy, e_pdo_vld, e_busy};
      e_rc   = {e_c1, e_c2};
      e_misc = {e_corr, e_tk1s, e_dom, e_dec};
      check("strobes", {srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse, erst}, e_strb);
      check("handshake", {bus.cmd_ready, bus.sdi_ready, bus.pdi_ready, bus.pdo_valid, busy}, e_hs);
      check("constants", {constant, constant2}, e_rc);
      check("context", {correct_cnt, tk1s, domain, decrypt}, e_misc);
      m_mode = nxt;

      if (xse)  xse_cnt++;
      if (yse)  yse_cnt++;
      if (sse)  sse_cnt++;
      if (zrst) zrst_cnt++;
      if (senc) begin
        enc_run++;
        if (enc_run == 1) begin first_c = constant; first_c2 = constant2; end
        if (erst) erst_pos = enc_run;
      end else if (enc_run != 0) begin
        last_len = enc_run;
        enc_run  = 0;
      end
    end
  end

  function automatic bit rnd(input int p_idle);
    return $urandom_range(0, 99) >= p_idle;
  endfunction

  // All driver tasks start and end at a falling edge, before any sampling.
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] dom, input logic dec);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_domain = dom; bus.cmd_dec = dec;
    #1;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.cmd_ready) check("cmd_timeout", 64'(n), 64'(0));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op = $urandom_range(0, 7);
    bus.cmd_dec = $urandom_range(0, 1);
  endtask

  // kind: 0 key words, 1 nonce/AD words, 2 MSG words, 3 tag words.
  task automatic drive_beats(input int kind, input int p_idle);
    int got = 0;
    int n   = 0;
    bit hit;
    while (got < 4 && n < 400) begin
      case (kind)
        0:       bus.sdi_valid = rnd(p_idle);
        3:       bus.pdo_ready = rnd(p_idle);
        default: begin bus.pdi_valid = rnd(p_idle); bus.pdo_ready = rnd(p_idle); end
      endcase
      #1;
      if (kind == 0)      hit = bus.sdi_valid && bus.sdi_ready;
      else if (kind == 3) hit = bus.pdo_valid && bus.pdo_ready;
      else                hit = bus.pdi_valid && bus.pdi_ready;
      if (hit) got++;
      n++;
      @(negedge clk);
    end
    bus.sdi_valid = 1'b0; bus.pdi_valid = 1'b0; bus.pdo_ready = 1'b0;
    if (got < 4) check("beat_timeout", 64'(got), 64'(4));
  endtask

  // Wait for IDLE while toggling word-channel inputs that must be ignored.
  task automatic wait_idle();
    int n = 0;
    bus.sdi_valid = rnd(50); bus.pdi_valid = rnd(50); bus.pdo_ready = rnd(50);
    #1;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      bus.sdi_valid = rnd(50); bus.pdi_valid = rnd(50); bus.pdo_ready = rnd(50);
      #1; n++;
    end
    if (!bus.cmd_ready) check("idle_timeout", 64'(n), 64'(0));
    @(negedge clk);
    bus.sdi_valid = 1'b0; bus.pdi_valid = 1'b0; bus.pdo_ready = 1'b0;
  endtask

  initial begin : main
    int x0, y0, z0, s0;
    logic [5:0] pat;
    logic [2:0] op;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_domain = '0; bus.cmd_dec = 1'b0;
    bus.sdi_valid = 1'b0; bus.pdi_valid = 1'b0; bus.pdo_ready = 1'b0;
    c_tbl[0] = 0;
    for (int k = 1; k <= 2*NCYC + 2; k++)
      c_tbl[k] = ((c_tbl[k-1] << 1) & 63) | (((c_tbl[k-1] >> 5) ^ (c_tbl[k-1] >> 4) ^ 1) & 1);
    check("model_c1", 64'(c_tbl[1]), 64'h01);
    check("model_c2", 64'(c_tbl[2]), 64'h03);
    check("model_c3", 64'(c_tbl[3]), 64'h07);
    check("model_c4", 64'(c_tbl[4]), 64'h0F);

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #2;
    check("por_cycle", {srst, xrst, yrst, bus.cmd_ready}, 4'b1110);
    @(negedge clk);
    #2;
    check("por_idle", {bus.cmd_ready, srst, xrst, yrst, senc, sse}, 6'b100000);
    @(negedge clk);

    // LDKEY with sdi_valid pattern 1,0,1,1,0,1.
    send_cmd(3'd0, 8'h00, 1'b0);
    x0  = xse_cnt;
    pat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      bus.sdi_valid = pat[i];
      #2;
      if (i == 5) check("key_busy6", {busy, bus.cmd_ready}, 2'b10);
      @(negedge clk);
    end
    bus.sdi_valid = 1'b0;
    #2;
    check("key_idle7", bus.cmd_ready, 1'b1);
    check("key_xse4", 64'(xse_cnt - x0), 64'(4));
    @(negedge clk);

    // LDNONCE then AD with domain 0x08.
    y0 = yse_cnt; z0 = zrst_cnt;
    send_cmd(3'd1, 8'h00, 1'b0);
    drive_beats(1, 40);
    check("nonce_yse4", 64'(yse_cnt - y0), 64'(4));
    check("nonce_zrst1", 64'(zrst_cnt - z0), 64'(1));
    s0 = sse_cnt;
    send_cmd(3'd2, 8'h08, 1'b0);
    check("ad_ctx", {tk1s, correct_cnt, domain}, {1'b1, 1'b1, 8'h08});
    drive_beats(1, 0);
    check("ad_sse4", 64'(sse_cnt - s0), 64'(4));
    wait_idle();
    check("enc_len", 64'(last_len), 64'(20));
    check("enc_erst_pos", 64'(erst_pos), 64'(20));
    check("enc_first_c", {first_c, first_c2}, {6'h01, 6'h03});

    // MSG decrypt, pdo_ready low for two cycles mid-block.
    s0 = sse_cnt;
    send_cmd(3'd3, 8'h04, 1'b1);
    check("msg_corr0", correct_cnt, 1'b0);
    pat = 6'b110011;
    for (int i = 0; i < 6; i++) begin
      bus.pdi_valid = 1'b1;
      bus.pdo_ready = pat[i];
      #2;
      if (i == 0) check("msg_decrypt", decrypt, DEC_EN ? 4'hF : 4'h0);
      if (i == 2 || i == 3) check("msg_stall", {sse, bus.pdi_ready, bus.pdo_valid}, 3'b001);
      @(negedge clk);
    end
    bus.pdi_valid = 1'b0; bus.pdo_ready = 1'b0;
    check("msg_sse4", 64'(sse_cnt - s0), 64'(4));
    wait_idle();

    // TAG: four pdo beats.
    s0 = sse_cnt;
    send_cmd(3'd4, 8'h05, 1'b1);
    check("tag_pdi_dec", {bus.pdi_ready, bus.pdo_valid, decrypt}, {1'b0, 1'b1, 4'h0});
    drive_beats(3, 30);
    check("tag_sse4", 64'(sse_cnt - s0), 64'(4));

    // Reset asserted on ENC cycle 10.
    send_cmd(3'd2, 8'h0A, 1'b0);
    drive_beats(1, 0);
    repeat (9) @(negedge clk);
    check("enc_mid", {senc, busy}, 2'b11);
    rst = 1'b0;
    #2;
    check("rst_async", {srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse, erst,
                        bus.cmd_ready, busy, constant, constant2, tk1s, domain}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    x0 = xse_cnt;
    send_cmd(3'd0, 8'h00, 1'b0);
    drive_beats(0, 25);
    check("rekey_xse4", 64'(xse_cnt - x0), 64'(4));

    // Randomized command stream.
    for (int it = 0; it < 40; it++) begin
      op = 3'($urandom_range(0, 7));
      send_cmd(op, 8'($urandom), 1'($urandom));
      case (op)
        3'd0:       drive_beats(0, 30);
        3'd1, 3'd2: drive_beats(1, 30);
        3'd3:       drive_beats(2, 30);
        3'd4:       drive_beats(3, 30);
        default:    ;
      endcase
      wait_idle();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
